axil_initiator_adaptor: RTL

AXIL_INITIATOR_ADAPTOR -- requirements
Module: axil_initiator_adaptor

---
 rtl/axil_initiator_adaptor.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/axil_initiator_adaptor.sv
// Bridges a simple valid/ready request/response port onto an AXI-lite master with one transaction in flight.
// States: IDLE accept, WRITE AW/W issue, WAIT_B, READ AR issue, WAIT_R, RESP hold response until consumed.
module axil_initiator_adaptor #(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32
) (
  input  logic                           clk_i,
  input  logic                           reset_i,

  input  logic                           v_i,
  output logic                           ready_and_o,
  input  logic [axil_addr_width_p-1:0]   addr_i,
  input  logic                           wr_en_i,
  input  logic [1:0]                     data_size_i,
  input  logic [axil_data_width_p-1:0]   wdata_i,

  output logic                           v_o,
  input  logic                           ready_and_i,
  output logic [axil_data_width_p-1:0]   rdata_o,
  output logic                           err_o,

  output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
  output logic [2:0]                     m_axil_awprot_o,
  output logic                           m_axil_awvalid_o,
  input  logic                           m_axil_awready_i,
  output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
  output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
  output logic                           m_axil_wvalid_o,
  input  logic                           m_axil_wready_i,
  input  logic [1:0]                     m_axil_bresp_i,
  input  logic                           m_axil_bvalid_i,
  output logic                           m_axil_bready_o,
  output logic [axil_addr_width_p-1:0]   m_axil_araddr_o,
  output logic [2:0]                     m_axil_arprot_o,
  output logic                           m_axil_arvalid_o,
  input  logic                           m_axil_arready_i,
  input  logic [axil_data_width_p-1:0]   m_axil_rdata_i,
  input  logic [1:0]                     m_axil_rresp_i,
  input  logic                           m_axil_rvalid_i,
  output logic                           m_axil_rready_o
);

  localparam int strb_w_lp = axil_data_width_p / 8;
  localparam int off_w_lp  = $clog2(strb_w_lp);
  localparam logic [3:0] strb_w_c = 4'(strb_w_lp);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_WAIT_B, ST_READ, ST_WAIT_R, ST_RESP
  } state_e;

  state_e                         state_q, state_d;
  logic                           init_q;
  logic [axil_addr_width_p-1:0]   addr_q, addr_d;
  logic [1:0]                     size_q, size_d;
  logic [axil_data_width_p-1:0]   wdata_q, wdata_d;
  logic                           aw_done_q, aw_done_d;
  logic                           w_done_q, w_done_d;
  logic [axil_data_width_p-1:0]   rdata_q, rdata_d;
  logic                           err_q, err_d;

  logic [3:0]                     req_bytes, bytes_q;
  logic                           req_illegal;
  logic [off_w_lp-1:0]            addr_off;
  logic [strb_w_lp-1:0]           lane_ones;
  logic [axil_data_width_p-1:0]   rd_mask, wdata_rep, rd_shift, rd_aligned;
  logic [2:0]                     src_lane;

  assign req_bytes   = 4'b1 << data_size_i;
  assign req_illegal = (req_bytes > strb_w_c)
                     | ((addr_i[2:0] & (req_bytes[2:0] - 3'd1)) != 3'd0);
  assign bytes_q     = 4'b1 << size_q;
  assign addr_off    = addr_q[off_w_lp-1:0];

  // Lane masks, and byte replication of the right-justified write data.
  always_comb begin
    lane_ones = '0;
    rd_mask   = '0;
    wdata_rep = '0;
    src_lane  = '0;
    for (int i = 0; i < strb_w_lp; i++) begin
      lane_ones[i]       = (4'(i) < bytes_q);
      rd_mask[8*i +: 8]  = (4'(i) < bytes_q) ? 8'hFF : 8'h00;
      src_lane           = 3'(i) & (bytes_q[2:0] - 3'd1);
      wdata_rep[8*i +: 8] = wdata_q[8*src_lane +: 8];
    end
  end

  assign rd_shift   = m_axil_rdata_i >> {addr_off, 3'b000};
  assign rd_aligned = rd_shift & rd_mask;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (v_i && ready_and_o) begin
          addr_d    = addr_i;
          size_d    = data_size_i;
          wdata_d   = wdata_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (req_illegal) begin
            state_d = ST_RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = wr_en_i ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_WRITE: begin
        aw_done_d = aw_done_q | m_axil_awready_i;
        w_done_d  = w_done_q | m_axil_wready_i;
        if (aw_done_d && w_done_d) state_d = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (m_axil_bvalid_i) begin
          state_d = ST_RESP;
          rdata_d = '0;
          err_d   = (m_axil_bresp_i != 2'b00);
        end
      end
      ST_READ: begin
        if (m_axil_arready_i) state_d = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        if (m_axil_rvalid_i) begin
          state_d = ST_RESP;
          rdata_d = rd_aligned;
          err_d   = (m_axil_rresp_i != 2'b00);
        end
      end
      ST_RESP: begin
        if (ready_and_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      init_q    <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= 1'b1;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // init_q keeps ready low until the first edge after reset is released.
  assign ready_and_o      = init_q && (state_q == ST_IDLE);
  assign v_o              = (state_q == ST_RESP);
  assign rdata_o          = {axil_data_width_p{v_o}} & rdata_q;
  assign err_o            = v_o & err_q;

  assign m_axil_awaddr_o  = addr_q;
  assign m_axil_awprot_o  = 3'b000;
  assign m_axil_awvalid_o = (state_q == ST_WRITE) && !aw_done_q;
  assign m_axil_wdata_o   = wdata_rep;
  assign m_axil_wstrb_o   = lane_ones << addr_off;
  assign m_axil_wvalid_o  = (state_q == ST_WRITE) && !w_done_q;
  assign m_axil_bready_o  = (state_q == ST_WAIT_B);
  assign m_axil_araddr_o  = addr_q;
  assign m_axil_arprot_o  = 3'b000;
  assign m_axil_arvalid_o = (state_q == ST_READ);
  assign m_axil_rready_o  = (state_q == ST_WAIT_R);

endmodule
